// File: rtl/nn_sched_pkg.sv
// Shared types and constants for the layer-chain scheduler: FSM states,
// default chain depth and the layer-order index names.
package nn_sched_pkg;

    localparam int NN_NUM_LAYERS = 8;

    // Layer order along the chain, ConV1 first.
    localparam int L_CONV1 = 0;
    localparam int L_CONV2 = 1;
    localparam int L_CONV3 = 2;
    localparam int L_CONV4 = 3;
    localparam int L_CONV5 = 4;
    localparam int L_FC1   = 5;
    localparam int L_FC2   = 6;
    localparam int L_FC3   = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_ERR
    } sched_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_layer_sched_if.sv
// Control and layer-handshake bundle between the scheduler (master) and the
// host plus layer engines (slave).
interface nn_layer_sched_if
    import nn_sched_pkg::*;
#(
    parameter int NUM_LAYERS = NN_NUM_LAYERS,
    parameter int CYC_W      = 32
);
    localparam int LW = idx_w(NUM_LAYERS);

    logic                  start_flag;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_done;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [LW-1:0]         layer_sel;
    logic                  busy;
    logic                  end_flag;
    logic                  err_timeout;
    logic [LW-1:0]         err_layer;
    logic [CYC_W-1:0]      cycle_cnt;

    modport master (
        input  start_flag, abort, layer_done,
        output layer_start, layer_sel, busy, end_flag, err_timeout, err_layer, cycle_cnt
    );

    modport slave (
        output start_flag, abort, layer_done,
        input  layer_start, layer_sel, busy, end_flag, err_timeout, err_layer, cycle_cnt
    );

endinterface

// File: rtl/nn_sched_wdog.sv
// Per-layer watchdog: counts enabled cycles, tc flags the cycle whose
// increment brings the count to all-ones.
module nn_sched_wdog #(
    parameter int W = 24
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [W-1:0] PRE_TERM = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == PRE_TERM);

endmodule

// File: rtl/nn_layer_sched.sv
// Sequences one inference through the layer chain: one start pulse per layer,
// advance on that layer's done, watchdog per layer, abort and cycle accounting.
module nn_layer_sched
    import nn_sched_pkg::*;
#(
    parameter int NUM_LAYERS = NN_NUM_LAYERS,
    parameter int TIMEOUT_W  = 24,
    parameter int CYC_W      = 32
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    nn_layer_sched_if.master bus
);
    localparam int                    LW        = idx_w(NUM_LAYERS);
    localparam logic [LW-1:0]         FIRST_IDX = LW'(L_CONV1);
    localparam logic [LW-1:0]         LAST_IDX  = LW'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] ONE_BIT   = NUM_LAYERS'(1);

    sched_state_t  state;
    logic [LW-1:0] idx;
    logic          in_run;
    logic          cur_done;
    logic          wd_tc;

    assign in_run        = (state == S_RUN);
    assign cur_done      = bus.layer_done[idx];
    assign bus.layer_sel = idx;

    nn_sched_wdog #(.W(TIMEOUT_W)) u_wdog (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clr     (!in_run),
        .en      (in_run),
        .tc      (wd_tc)
    );

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            idx             <= '0;
            bus.layer_start <= '0;
            bus.busy        <= 1'b0;
            bus.end_flag    <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.err_layer   <= '0;
            bus.cycle_cnt   <= '0;
        end else begin
            bus.layer_start <= '0;
            bus.end_flag    <= 1'b0;
            if (bus.busy && bus.cycle_cnt != '1)
                bus.cycle_cnt <= bus.cycle_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.start_flag) begin
                        idx             <= FIRST_IDX;
                        bus.cycle_cnt   <= '0;
                        bus.err_timeout <= 1'b0;
                        bus.layer_start <= ONE_BIT;
                        bus.busy        <= 1'b1;
                        state           <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (bus.abort) begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Priority: abort, then done, then watchdog expiry.
                    if (bus.abort) begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end else if (cur_done) begin
                        if (idx == LAST_IDX) begin
                            bus.busy     <= 1'b0;
                            bus.end_flag <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            idx             <= idx + 1'b1;
                            bus.layer_start <= ONE_BIT << (idx + 1'b1);
                            state           <= S_LAUNCH;
                        end
                    end else if (wd_tc) begin
                        bus.busy        <= 1'b0;
                        bus.err_timeout <= 1'b1;
                        bus.err_layer   <= idx;
                        state           <= S_ERR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sched.sv
// Directed bench for nn_layer_sched with NUM_LAYERS=8, TIMEOUT_W=6.
module tb_nn_layer_sched;
    import nn_sched_pkg::*;

    localparam int NL = 8;
    localparam int TW = 6;
    localparam int CW = 32;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    int   t0      = 0;
    int   base_ls = 0;
    int   base_ef = 0;
    int   ls_cnt[NL] = '{default: 0};
    int   ef_cnt  = 0;

    nn_layer_sched_if #(.NUM_LAYERS(NL), .CYC_W(CW)) bus ();

    nn_layer_sched #(.NUM_LAYERS(NL), .TIMEOUT_W(TW), .CYC_W(CW)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        for (int i = 0; i < NL; i++)
            if (bus.layer_start[i]) ls_cnt[i]++;
        if (bus.end_flag) ef_cnt++;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_inf();
        bus.start_flag = 1'b1;
        t0 = cyc;
        tick();
        bus.start_flag = 1'b0;
    endtask

    // Entered on the layer's start cycle; done is driven 5 cycles after start.
    task automatic do_layer(input int k, input bit noisy);
        chk($sformatf("start_l%0d", k), bus.layer_start, 64'(1) << k);
        chk($sformatf("sel_l%0d", k), bus.layer_sel, k);
        for (int j = 1; j <= 5; j++) begin
            tick();
            bus.layer_done = '0;
            bus.start_flag = 1'b0;
            if (j == 1) chk($sformatf("pulse_len_l%0d", k), bus.layer_start, 0);
            if (noisy && k == 1 && j == 2) bus.layer_done = 8'h20;
            if (noisy && k == 1 && j == 3) bus.start_flag = 1'b1;
            if (j == 5) bus.layer_done = NL'(1) << k;
        end
        tick();
        bus.layer_done = '0;
    endtask

    task automatic finish_chk(input int exp_cc);
        chk("end_flag", bus.end_flag, 1);
        chk("busy_in_done", bus.busy, 0);
        chk("err_in_done", bus.err_timeout, 0);
        chk("cycle_cnt_done", bus.cycle_cnt, exp_cc);
        bus.start_flag = 1'b1;
        tick();
        bus.start_flag = 1'b0;
        chk("end_one_cycle", bus.end_flag, 0);
        chk("start_in_done_ignored", bus.busy, 0);
        chk("no_start_after_done", bus.layer_start, 0);
        chk("sel_hold_idle", bus.layer_sel, 7);
        chk("cycle_cnt_hold", bus.cycle_cnt, exp_cc);
    endtask

    initial begin
        bus.start_flag = 1'b0;
        bus.abort      = 1'b0;
        bus.layer_done = '0;
        repeat (3) tick();
        chk("rst_layer_start", bus.layer_start, 0);
        chk("rst_layer_sel", bus.layer_sel, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_end_flag", bus.end_flag, 0);
        chk("rst_err_timeout", bus.err_timeout, 0);
        chk("rst_cycle_cnt", bus.cycle_cnt, 0);
        rst_n = 1'b1;
        while (cyc < 10) tick();

        // Full clean inference starting at cycle 10.
        start_inf();
        chk("busy_launch", bus.busy, 1);
        for (int k = 0; k < NL; k++) do_layer(k, 1'b0);
        finish_chk(48);

        // Abort during LAUNCH: the pulse is already out, then idle.
        start_inf();
        chk("ls_before_abort", bus.layer_start, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_launch_busy", bus.busy, 0);
        chk("abort_launch_ls", bus.layer_start, 0);
        chk("abort_launch_cc", bus.cycle_cnt, 1);
        tick();

        // Layer 3 hangs: watchdog error after 63 RUN cycles.
        base_ls = ls_cnt[4];
        base_ef = ef_cnt;
        start_inf();
        for (int k = 0; k < 3; k++) do_layer(k, 1'b0);
        chk("start_l3_hang", bus.layer_start, 8'h08);
        repeat (63) tick();
        chk("wd_not_yet", bus.err_timeout, 0);
        chk("wd_busy_last_run", bus.busy, 1);
        tick();
        chk("err_timeout", bus.err_timeout, 1);
        chk("err_layer", bus.err_layer, 3);
        chk("err_busy", bus.busy, 0);
        chk("err_cycle_cnt", bus.cycle_cnt, 82);
        bus.start_flag = 1'b1;
        tick();
        bus.start_flag = 1'b0;
        chk("start_in_err_ignored", bus.busy, 0);
        chk("err_sticky", bus.err_timeout, 1);
        repeat (3) tick();
        chk("no_start_l4", ls_cnt[4] - base_ls, 0);
        chk("no_end_on_err", ef_cnt - base_ef, 0);

        // Abort coincident with layer_done[2].
        base_ls = ls_cnt[3];
        base_ef = ef_cnt;
        start_inf();
        chk("err_clr_on_start", bus.err_timeout, 0);
        for (int k = 0; k < 2; k++) do_layer(k, 1'b0);
        chk("start_l2", bus.layer_start, 8'h04);
        repeat (5) tick();
        bus.layer_done = 8'h04;
        bus.abort      = 1'b1;
        tick();
        bus.layer_done = '0;
        bus.abort      = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_ls", bus.layer_start, 0);
        chk("abort_err", bus.err_timeout, 0);
        chk("abort_cycle_cnt", bus.cycle_cnt, 18);
        repeat (3) tick();
        chk("abort_no_start_l3", ls_cnt[3] - base_ls, 0);
        chk("abort_no_end", ef_cnt - base_ef, 0);

        // Layer 7 done on the watchdog terminal-count cycle: done wins.
        start_inf();
        for (int k = 0; k < 7; k++) do_layer(k, 1'b0);
        chk("start_l7", bus.layer_start, 8'h80);
        repeat (63) tick();
        bus.layer_done = 8'h80;
        tick();
        bus.layer_done = '0;
        chk("tie_end_flag", bus.end_flag, 1);
        chk("tie_no_err", bus.err_timeout, 0);
        chk("tie_busy", bus.busy, 0);
        chk("tie_cycle_cnt", bus.cycle_cnt, 106);
        tick();

        // Reset during layer 6 RUN, then a run with noise on the inputs.
        start_inf();
        for (int k = 0; k < 6; k++) do_layer(k, 1'b0);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_layer_start", bus.layer_start, 0);
        chk("mid_rst_layer_sel", bus.layer_sel, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_end_flag", bus.end_flag, 0);
        chk("mid_rst_err_layer", bus.err_layer, 0);
        chk("mid_rst_cycle_cnt", bus.cycle_cnt, 0);
        tick();
        start_inf();
        for (int k = 0; k < NL; k++) do_layer(k, 1'b1);
        finish_chk(48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
